// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between the EX issue path (0) and the branch helper (1).
// Optional per-requester grant counters are enabled by defining ALU_SHARE_ARB_GRANT_CNT_EN.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [5:0]       req_opcode_0,
    input  logic [5:0]       req_opcode_1,
    input  logic [5:0]       req_func_0,
    input  logic [5:0]       req_func_1,
    input  logic [4:0]       req_sa_0,
    input  logic [4:0]       req_sa_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    output logic             resp_valid_0,
    output logic             resp_valid_1,
    input  logic             resp_ready_0,
    input  logic             resp_ready_1,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic [WIDTH-1:0] alu_first,
    output logic [WIDTH-1:0] alu_second,
    output logic [5:0]       alu_opcode,
    output logic [5:0]       alu_func,
    output logic [4:0]       alu_sa,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
   ,output logic [CNT_W-1:0] grant_cnt_0,
    output logic [CNT_W-1:0] grant_cnt_1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_first_q, alu_first_d;
    logic [WIDTH-1:0] alu_second_q, alu_second_d;
    logic [5:0]       alu_opcode_q, alu_opcode_d;
    logic [5:0]       alu_func_q, alu_func_d;
    logic [4:0]       alu_sa_q, alu_sa_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic             resp_zero_q, resp_zero_d;

    logic [1:0]       vld, rdy, rsp_vld, rsp_rdy;
    logic             grant_sel;
    logic             accept;

    assign vld     = {req_valid_1, req_valid_0};
    assign rsp_rdy = {resp_ready_1, resp_ready_0};
    // Contention goes to rr_ptr; a lone requester wins outright.
    assign grant_sel = (vld == 2'b11) ? rr_ptr_q : vld[1];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        alu_first_d   = alu_first_q;
        alu_second_d  = alu_second_q;
        alu_opcode_d  = alu_opcode_q;
        alu_func_d    = alu_func_q;
        alu_sa_d      = alu_sa_q;
        resp_result_d = resp_result_q;
        resp_zero_d   = resp_zero_q;
        rdy           = 2'b00;
        rsp_vld       = 2'b00;
        accept        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|vld) begin
                    accept         = 1'b1;
                    rdy[grant_sel] = 1'b1;
                    owner_d        = grant_sel;
                    cnt_d          = 3'(LATENCY);
                    state_d        = EXEC;
                    if (grant_sel) begin
                        alu_first_d  = req_a_1;
                        alu_second_d = req_b_1;
                        alu_opcode_d = req_opcode_1;
                        alu_func_d   = req_func_1;
                        alu_sa_d     = req_sa_1;
                    end else begin
                        alu_first_d  = req_a_0;
                        alu_second_d = req_b_0;
                        alu_opcode_d = req_opcode_0;
                        alu_func_d   = req_func_0;
                        alu_sa_d     = req_sa_0;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == 3'd0) begin
                    resp_result_d = alu_result;
                    resp_zero_d   = alu_zero;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                rsp_vld[owner_q] = 1'b1;
                if (rsp_rdy[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            alu_first_q   <= '0;
            alu_second_q  <= '0;
            alu_opcode_q  <= '0;
            alu_func_q    <= '0;
            alu_sa_q      <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            alu_first_q   <= alu_first_d;
            alu_second_q  <= alu_second_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_func_q    <= alu_func_d;
            alu_sa_q      <= alu_sa_d;
            resp_result_q <= resp_result_d;
            resp_zero_q   <= resp_zero_d;
        end
    end

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    logic [1:0][CNT_W-1:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (accept && !(&gcnt_q[grant_sel]))
            gcnt_d[grant_sel] = gcnt_q[grant_sel] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) gcnt_q <= '0;
        else     gcnt_q <= gcnt_d;
    end

    assign grant_cnt_0 = gcnt_q[0];
    assign grant_cnt_1 = gcnt_q[1];
`endif

    assign req_ready_0  = rdy[0];
    assign req_ready_1  = rdy[1];
    assign resp_valid_0 = rsp_vld[0];
    assign resp_valid_1 = rsp_vld[1];
    assign resp_result  = resp_result_q;
    assign resp_zero    = resp_zero_q;
    assign alu_first    = alu_first_q;
    assign alu_second   = alu_second_q;
    assign alu_opcode   = alu_opcode_q;
    assign alu_func     = alu_func_q;
    assign alu_sa       = alu_sa_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a small registered ALU model on the alu_* bus.
module tb_alu_share_arbiter;
    localparam int WIDTH = 32;
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [5:0]       req_opcode_0, req_opcode_1, req_func_0, req_func_1;
    logic [4:0]       req_sa_0, req_sa_1;
    logic [WIDTH-1:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic             resp_valid_0, resp_valid_1, resp_ready_0, resp_ready_1;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;
    logic [WIDTH-1:0] alu_first, alu_second;
    logic [5:0]       alu_opcode, alu_func;
    logic [4:0]       alu_sa;
    logic [WIDTH-1:0] alu_result = '0;
    logic             alu_zero = 1'b0;
    logic             busy;
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] grant_cnt_0, grant_cnt_1;
`endif

    alu_share_arbiter #(.WIDTH(WIDTH), .LATENCY(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
        .req_func_0(req_func_0), .req_func_1(req_func_1),
        .req_sa_0(req_sa_0), .req_sa_1(req_sa_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_first(alu_first), .alu_second(alu_second),
        .alu_opcode(alu_opcode), .alu_func(alu_func), .alu_sa(alu_sa),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
       ,.grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
`endif
    );

    // One-cycle registered ALU: R-type by func, beq subtracts, anything else adds.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [5:0] op, input logic [5:0] fn,
                                                input logic [4:0] sa, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        if (op == 6'b000100) return a - b;
        if (op != 6'b000000) return a + b;
        case (fn)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b000000: return b << sa;
            default:   return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_result <= alu_fn(alu_opcode, alu_func, alu_sa, alu_first, alu_second);
        alu_zero   <= (alu_fn(alu_opcode, alu_func, alu_sa, alu_first, alu_second) == '0);
    end

    typedef struct {
        int               r;
        logic [WIDTH-1:0] res;
        logic             z;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input int r, input logic [WIDTH-1:0] res, input logic z);
        exp_t e;
        e.r = r; e.res = res; e.z = z;
        sbq.push_back(e);
    endtask

    // Monitor: every completed response handshake is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid_0 && resp_valid_1) chk("dual_resp_valid", {resp_valid_1, resp_valid_0}, 32'd1);
        for (int r = 0; r < 2; r++) begin
            if ((r == 0) ? (resp_valid_0 && resp_ready_0) : (resp_valid_1 && resp_ready_1)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_resp: requester %0d result %0h, none expected", r, resp_result);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_owner", r, e.r);
                    chk("resp_result", resp_result, e.res);
                    chk("resp_zero", resp_zero, e.z);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] sa, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (r == 0) begin
            req_valid_0 = 1'b1; req_opcode_0 = op; req_func_0 = fn; req_sa_0 = sa; req_a_0 = a; req_b_0 = b;
        end else begin
            req_valid_1 = 1'b1; req_opcode_1 = op; req_func_1 = fn; req_sa_1 = sa; req_a_1 = a; req_b_1 = b;
        end
    endtask

    task automatic clr_req(input int r);
        if (r == 0) req_valid_0 = 1'b0;
        else        req_valid_1 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) chk({name, "_idle_timeout"}, busy, 32'd0);
    endtask

    task automatic wait_ready(input int r, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((r == 0) ? req_ready_0 : req_ready_1) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_op(input int r, input logic [5:0] op, input logic [5:0] fn,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] res, input logic z, input string name);
        expect_resp(r, res, z);
        set_req(r, op, fn, 5'd0, a, b);
        #1;
        wait_ready(r, name);
        tick();
        clr_req(r);
        wait_idle(name);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_g[4];
        int n;
        exp_g = '{0, 1, 0, 1};
        rst = 1'b1;
        req_valid_0 = 0; req_valid_1 = 0;
        req_opcode_0 = 0; req_opcode_1 = 0; req_func_0 = 0; req_func_1 = 0;
        req_sa_0 = 0; req_sa_1 = 0; req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
        resp_ready_0 = 0; resp_ready_1 = 0;
        do_reset();

        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", {resp_valid_1, resp_valid_0}, 0);
        chk("rst_alu_first", alu_first, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_req_ready", {req_ready_1, req_ready_0}, 0);
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
        chk("rst_grant_cnt", {grant_cnt_1, grant_cnt_0}, 0);
`endif

        // Scenario 1: single add on requester 0, latency check
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b0;
        expect_resp(0, 32'd12, 1'b0);
        set_req(0, 6'b000000, 6'b100000, 5'd3, 32'd5, 32'd7);
        #1;
        chk("s1_req_ready_0", req_ready_0, 1);
        chk("s1_req_ready_1", req_ready_1, 0);
        tick();
        clr_req(0);
        chk("s1_busy", busy, 1);
        chk("s1_alu_first", alu_first, 5);
        chk("s1_alu_second", alu_second, 7);
        chk("s1_alu_opcode", alu_opcode, 0);
        chk("s1_alu_func", alu_func, 6'b100000);
        chk("s1_alu_sa", alu_sa, 3);
        chk("s1_resp_valid_e0", resp_valid_0, 0);
        tick();
        chk("s1_resp_valid_e1", resp_valid_0, 0);
        tick();
        chk("s1_resp_valid_e2", resp_valid_0, 1);
        chk("s1_resp_valid_1", resp_valid_1, 0);
        tick();
        chk("s1_busy_after", busy, 0);
        chk("s1_alu_hold", alu_first, 5);

        // Scenario 2: simultaneous requests after reset, requester 0 wins
        do_reset();
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        expect_resp(0, 32'd0, 1'b1);
        expect_resp(1, 32'hFF, 1'b0);
        set_req(0, 6'b000100, 6'b000000, 5'd0, 32'd9, 32'd9);
        set_req(1, 6'b000000, 6'b100101, 5'd0, 32'hF0, 32'h0F);
        #1;
        chk("s2_ready_0", req_ready_0, 1);
        chk("s2_ready_1", req_ready_1, 0);
        tick();
        clr_req(0);
        chk("s2_exec_ready_1", req_ready_1, 0);
        wait_ready(1, "s2");
        tick();
        clr_req(1);
        wait_idle("s2");

        // Scenario 3: response back-pressure holds the bus and blocks requester 1
        resp_ready_0 = 1'b0;
        expect_resp(0, 32'h0F00, 1'b0);
        set_req(0, 6'b000000, 6'b100100, 5'd0, 32'hFF00, 32'h0FF0);
        #1;
        wait_ready(0, "s3");
        tick();
        clr_req(0);
        expect_resp(1, 32'd3, 1'b0);
        set_req(1, 6'b000000, 6'b100000, 5'd0, 32'd1, 32'd2);
        for (int i = 0; i < 20 && !resp_valid_0; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("s3_hold_valid", resp_valid_0, 1);
            chk("s3_hold_result", resp_result, 32'h0F00);
            chk("s3_block_ready_1", req_ready_1, 0);
            tick();
        end
        resp_ready_0 = 1'b1;
        tick();
        chk("s3_idle_busy", busy, 0);
        chk("s3_idle_ready_1", req_ready_1, 1);
        tick();
        clr_req(1);
        wait_idle("s3");

        // Scenario 4: both held valid for four operations, alternating grants
        do_reset();
        expect_resp(0, 32'd7, 1'b0);
        expect_resp(1, 32'h33, 1'b0);
        expect_resp(0, 32'd7, 1'b0);
        expect_resp(1, 32'h33, 1'b0);
        set_req(0, 6'b000000, 6'b100000, 5'd0, 32'd3, 32'd4);
        set_req(1, 6'b000000, 6'b100101, 5'd0, 32'h30, 32'h03);
        #1;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
            chk("s4_busy_vs_idle", busy, !(req_ready_0 || req_ready_1));
            if (req_ready_0 || req_ready_1) begin
                chk("s4_grant_order", req_ready_1 ? 1 : 0, exp_g[n]);
                n++;
            end
            tick();
        end
        clr_req(0);
        clr_req(1);
        chk("s4_grant_total", n, 4);
        wait_idle("s4");
`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
        chk("s4_grant_cnt_0", grant_cnt_0, 2);
        chk("s4_grant_cnt_1", grant_cnt_1, 2);
`endif

        // Scenario 5: reset during EXEC abandons the operation and clears rr_ptr
        do_op(0, 6'b000000, 6'b100000, 32'd2, 32'd2, 32'd4, 1'b0, "s5_pre");
        set_req(1, 6'b000000, 6'b100000, 5'd1, 32'd8, 32'd8);
        #1;
        chk("s5_ready_1", req_ready_1, 1);
        tick();
        clr_req(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s5_busy", busy, 0);
        chk("s5_alu_first", alu_first, 0);
        chk("s5_alu_second", alu_second, 0);
        chk("s5_alu_opfunc", {alu_opcode, alu_func, alu_sa}, 0);
        chk("s5_resp", {resp_result, resp_zero}, 0);
        chk("s5_resp_valid", {resp_valid_1, resp_valid_0}, 0);
        for (int i = 0; i < 5; i++) begin
            chk("s5_no_resp", resp_valid_1, 0);
            tick();
        end
        expect_resp(0, 32'd6, 1'b0);
        expect_resp(1, 32'd1, 1'b0);
        set_req(0, 6'b000000, 6'b100000, 5'd0, 32'd1, 32'd5);
        set_req(1, 6'b000000, 6'b100010, 5'd0, 32'd3, 32'd2);
        #1;
        chk("s5_dual_ready_0", req_ready_0, 1);
        chk("s5_dual_ready_1", req_ready_1, 0);
        tick();
        clr_req(0);
        wait_ready(1, "s5");
        tick();
        clr_req(1);
        wait_idle("s5");

`ifdef ALU_SHARE_ARB_GRANT_CNT_EN
        // Scenario 6: counter saturates at all-ones for CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++)
            do_op(0, 6'b000000, 6'b100000, 32'(i), 32'd1, 32'(i + 1), 1'b0, "s6");
        chk("s6_grant_cnt_0_sat", grant_cnt_0, 3);
        chk("s6_grant_cnt_1", grant_cnt_1, 0);
`endif

        tick();
        tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single registered ALU between two requesters: requester 0 is the EX-stage issue path, requester 1 is the branch/compare helper.
- Accepts one operation at a time through a valid/ready handshake, using round-robin priority.
- Drives the ALU operand/opcode/func/sa inputs from registers and waits a fixed latency.
- Captures the ALU result and zero flag, then returns them to the owning requester through a second valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width
LATENCY, 1, cycles from ALU input change to ALU result valid (legal range 1..7)
CNT_W, 16, grant-counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid_N  in  1  request valid, N=0,1
req_ready_N  out  1  request accepted this cycle, N=0,1
req_opcode_N  in  6  instruction opcode field, N=0,1
req_func_N  in  6  instruction func field, N=0,1
req_sa_N  in  5  shift amount, N=0,1
req_a_N  in  WIDTH  first operand, N=0,1
req_b_N  in  WIDTH  second operand/immediate, N=0,1
resp_valid_N  out  1  result available for requester N
resp_ready_N  in  1  requester N takes result
resp_result  out  WIDTH  captured ALU result (shared bus)
resp_zero  out  1  captured ALU zero flag
alu_first  out  WIDTH  to ALU firstVal
alu_second  out  WIDTH  to ALU secondVal
alu_opcode  out  6  to ALU opcode
alu_func  out  6  to ALU func
alu_sa  out  5  to ALU sa
alu_result  in  WIDTH  from ALU
alu_zero  in  1  from ALU
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. On reset:
  - state=IDLE, rr_ptr=0, owner=0.
  - All alu_* outputs, resp_result and resp_zero are 0.
  - resp_valid_N=0 and busy=0.
  - Any in-flight operation is abandoned; it produces no response.
- State machine: IDLE -> EXEC -> RESP -> IDLE. Only one operation is outstanding at a time.
- IDLE:
  - req_ready_N is combinational.
  - If exactly one req_valid_N is high, req_ready_N=1 for it.
  - If both are high, req_ready is asserted only for requester rr_ptr; the loser must hold its request stable.
  - On the accept edge, latch that requester's opcode/func/sa/a/b into the alu_* registers, set owner, load cnt=LATENCY, and go to EXEC.
- EXEC:
  - req_ready_N=0, and alu_* stay constant.
  - cnt decrements each cycle.
  - On the edge where cnt==0, capture alu_result into resp_result and alu_zero into resp_zero, then go to RESP.
  - Net effect: capture happens on the (LATENCY+1)th edge after the accept edge.
- RESP:
  - resp_valid_owner=1; the other resp_valid is 0.
  - resp_result and resp_zero are held until resp_ready_owner=1.
  - On the handshake edge: go to IDLE, rr_ptr = ~owner (the other requester gets priority next).
  - No acceptance is allowed in RESP. Throughput is one operation per LATENCY+3 cycles minimum.
- No decode: opcode/func/sa pass through unmodified. Branch users consume resp_zero.
- alu_* outputs keep their last issued values in IDLE and RESP (no toggling).
- If resp_ready is asserted by a non-owner, it is ignored.
- If a req_valid drops before it is accepted, the request is simply not taken; this is not an error.

Optional Feature:
- Macro ALU_SHARE_ARB_GRANT_CNT_EN.
- When defined:
  - Adds outputs grant_cnt_0 and grant_cnt_1, each CNT_W bits.
  - Each counter increments on every accept edge for its requester and saturates at all-ones.
  - Both counters clear on rst.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
1. LATENCY=1; req0 add (opcode 000000, func 100000, a=5, b=7) with resp_ready_0=1 -> req_ready_0 high in the accept cycle; resp_valid_0 high after the 2nd edge following accept; resp_result=12, resp_zero=0; resp_valid_1 stays 0.
2. After reset, both requests valid in the same cycle: req0 beq (opcode 000100, a=9, b=9), req1 or (func 100101, a=0xF0, b=0x0F) -> req0 served first with resp_zero=1; then req1 with resp_result=0xFF.
3. req0 op completes while resp_ready_0 is held low for 5 cycles and req1 is valid -> resp_valid_0 and resp_result stay stable and req_ready_1 stays 0 until the handshake; req1 is accepted in the IDLE cycle that follows.
4. Both requesters held valid for 4 operations, with responses taken immediately -> grant order 0,1,0,1; busy drops only in the IDLE cycles between operations.
5. rst pulsed for 1 cycle while in EXEC -> no resp_valid ever asserted for that operation; all outputs 0 next cycle; the next dual request is granted to req0.
6. Macro defined: after scenario 4, grant_cnt_0=2 and grant_cnt_1=2. With CNT_W=2, 5 grants to req0 -> grant_cnt_0=3 (saturated).
